stream_fifo: RTL and testbench

//   Single-clock valid/ready FIFO built around the team's simple dual-port RAM.

---
 rtl/stream_fifo_pkg.sv | 12 +
 rtl/simple_dual_ram.sv | 35 +++
 rtl/stream_fifo_chk.sv | 19 +
 rtl/stream_fifo.sv | 130 +++++++++++++
 tb/tb_stream_fifo.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared defaults and helpers for the stream FIFO slice.
package stream_fifo_pkg;

  localparam int unsigned SF_WIDTH_DEF = 8;
  localparam int unsigned SF_DEPTH_DEF = 16;

  // The output stage adds one word on top of the RAM, so the level counts 0..DEPTH+1.
  function automatic int unsigned sf_level_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/simple_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module simple_dual_ram
  import stream_fifo_pkg::*;
#(
  parameter int unsigned SIZE  = SF_WIDTH_DEF,
  parameter int unsigned DEPTH = SF_DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic            wclk,
  input  logic            write_en,
  input  logic [AW-1:0]   waddr,
  input  logic [SIZE-1:0] write_data,
  input  logic            rclk,
  input  logic            read_en,
  input  logic [AW-1:0]   raddr,
  output logic [SIZE-1:0] read_data
);

  logic [SIZE-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge wclk) begin
    if (write_en) begin
      mem_q[waddr] <= write_data;
    end
  end

  // Registered read port; contents are deliberately left unreset.
  always_ff @(posedge rclk) begin
    if (read_en) begin
      read_data <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/stream_fifo_chk.sv
// Invariant checker for stream_fifo output-stage and level bookkeeping.
module stream_fifo_chk #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = 5
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rd_pend,
  input logic          hold_valid,
  input logic [LW-1:0] level
);

  a_stage_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_pend && hold_valid));

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level <= LW'(DEPTH + 1));

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO over a simple dual-port RAM with a first-word-fall-through output stage.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = SF_WIDTH_DEF,
  parameter int unsigned DEPTH = SF_DEPTH_DEF,
  localparam int unsigned LW   = sf_level_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] ram_rdata_s;
  logic             ram_empty_s, ram_full_s;
  logic             push_s, pop_s, rd_issue_s;

  assign ram_empty_s = (wptr_q == rptr_q);
  assign ram_full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign in_ready  = !ram_full_s;
  assign out_valid = rd_pend_q | hold_valid_q;
  // Read data is forced to zero when no read is in flight so an idle output is deterministic.
  assign out_data  = hold_valid_q ? hold_data_q :
                     (rd_pend_q ? ram_rdata_s : {WIDTH{1'b0}});
  assign level     = level_q;

  assign push_s     = in_valid & in_ready;
  assign pop_s      = out_valid & out_ready;
  assign rd_issue_s = !ram_empty_s & !(out_valid & !out_ready);

  simple_dual_ram #(
    .SIZE  (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .wclk       (clk),
    .write_en   (push_s & !clear),
    .waddr      (wptr_q[AW-1:0]),
    .write_data (in_data),
    .rclk       (clk),
    .read_en    (rd_issue_s & !clear),
    .raddr      (rptr_q[AW-1:0]),
    .read_data  (ram_rdata_s)
  );

  // Next-state for pointers, output stage and level; clear overrides every event.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    rd_pend_d    = 1'b0;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    level_d      = level_q;
    if (clear) begin
      wptr_d       = {PW{1'b0}};
      rptr_d       = {PW{1'b0}};
      rd_pend_d    = 1'b0;
      hold_valid_d = 1'b0;
      level_d      = {LW{1'b0}};
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + PW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_issue_s) begin
        rptr_d    = rptr_q + PW'(1);
        rd_pend_d = 1'b1;
      end else begin
        rd_pend_d = 1'b0;
      end
      // A landing read word the consumer does not take is parked in the hold register.
      if (rd_pend_q && !out_ready) begin
        hold_valid_d = 1'b1;
        hold_data_d  = ram_rdata_s;
      end else if (pop_s && hold_valid_q) begin
        hold_valid_d = 1'b0;
      end else begin
        hold_valid_d = hold_valid_q;
      end
      level_d = level_q + LW'(push_s) - LW'(pop_s);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q       <= {PW{1'b0}};
      rptr_q       <= {PW{1'b0}};
      rd_pend_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= {WIDTH{1'b0}};
      level_q      <= {LW{1'b0}};
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rd_pend_q    <= rd_pend_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      level_q      <= level_d;
    end
  end

  stream_fifo_chk #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_pend    (rd_pend_q),
    .hold_valid (hold_valid_q),
    .level      (level_q)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed and scoreboarded bench for stream_fifo (WIDTH=8, DEPTH=16).
module tb_stream_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH + 2);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;

  int n_vec;
  int n_miss;

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic scen1();
    check_vec("rst_out_valid", 32'(out_valid), 32'd0);
    check_vec("rst_in_ready", 32'(in_ready), 32'd1);
    check_vec("rst_level", 32'(level), 32'd0);
    check_vec("rst_out_data", 32'(out_data), 32'h00);
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    check_vec("s1_lat_valid", 32'(out_valid), 32'd0);
    check_vec("s1_lat_level", 32'(level), 32'd1);
    tick();
    check_vec("s1_valid", 32'(out_valid), 32'd1);
    check_vec("s1_data", 32'(out_data), 32'hA5);
    check_vec("s1_level", 32'(level), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_vec("s1_hold_valid", 32'(out_valid), 32'd1);
      check_vec("s1_hold_data", 32'(out_data), 32'hA5);
    end
  endtask

  initial begin
    int          acc;
    int          cnt;
    int          mlevel;
    int          pushed;
    int          cyc;
    logic        p;
    logic        r;
    logic [7:0]  sb[$];
    logic [7:0]  expd;

    n_vec  = 0;
    n_miss = 0;

    // 1: single word latency and hold
    reset_dut();
    scen1();

    // 2: fill to capacity, pop one from full, refill, drain in order
    reset_dut();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check_vec("s2_accepted", 32'(acc), 32'd17);
    check_vec("s2_full_level", 32'(level), 32'd17);
    check_vec("s2_full_ready", 32'(in_ready), 32'd0);
    check_vec("s2_head", 32'(out_data), 32'h00);
    out_ready = 1'b1;
    tick();
    check_vec("s2_ready_rise", 32'(in_ready), 32'd1);
    check_vec("s2_level_16", 32'(level), 32'd16);
    check_vec("s2_next", 32'(out_data), 32'h01);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd17;
    tick();
    in_valid = 1'b0;
    check_vec("s2_refull_level", 32'(level), 32'd17);
    check_vec("s2_refull_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      check_vec("s2_drain_valid", 32'(out_valid), 32'd1);
      check_vec("s2_drain_data", 32'(out_data), 32'(j));
      tick();
    end
    out_ready = 1'b0;
    check_vec("s2_empty_valid", 32'(out_valid), 32'd0);
    check_vec("s2_empty_level", 32'(level), 32'd0);

    // 3: streaming at one word per cycle
    reset_dut();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      in_data = 8'(cnt);
      tick();
      cnt++;
      if (k == 1) begin
        check_vec("s3_fill_valid", 32'(out_valid), 32'd0);
        check_vec("s3_fill_level", 32'(level), 32'd1);
      end else begin
        check_vec("s3_valid", 32'(out_valid), 32'd1);
        check_vec("s3_data", 32'(out_data), 32'(8'(k - 2)));
        check_vec("s3_level", 32'(level), 32'd2);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // 4: random handshakes against a scoreboard
    reset_dut();
    mlevel = 0;
    pushed = 0;
    cyc    = 0;
    while ((pushed < 10000 || sb.size() != 0) && cyc < 60000) begin
      check_vec("s4_level", 32'(level), 32'(mlevel));
      in_valid  = (pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      p = in_valid & in_ready;
      r = out_valid & out_ready;
      if (!in_ready) check_vec("s4_full_level", 32'(mlevel >= DEPTH), 32'd1);
      if (r) begin
        check_vec("s4_sb_avail", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          expd = sb.pop_front();
          check_vec("s4_data", 32'(out_data), 32'(expd));
        end
      end
      if (p) begin
        sb.push_back(in_data);
        pushed++;
      end
      mlevel = mlevel + int'(p) - int'(r);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_vec("s4_drained", 32'(sb.size()), 32'd0);
    check_vec("s4_pushed", 32'(pushed), 32'd10000);
    check_vec("s4_end_level", 32'(level), 32'd0);

    // 5: clear with a read pending
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h90 + i);
      tick();
    end
    in_valid = 1'b0;
    check_vec("s5_level10", 32'(level), 32'd10);
    out_ready = 1'b1;
    tick();
    check_vec("s5_level9", 32'(level), 32'd9);
    check_vec("s5_pend_data", 32'(out_data), 32'h91);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_vec("s5_clr_level", 32'(level), 32'd0);
    check_vec("s5_clr_valid", 32'(out_valid), 32'd0);
    check_vec("s5_clr_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    check_vec("s5_lat_valid", 32'(out_valid), 32'd0);
    tick();
    check_vec("s5_first_valid", 32'(out_valid), 32'd1);
    check_vec("s5_first_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_vec("s5_after_valid", 32'(out_valid), 32'd0);
    check_vec("s5_after_level", 32'(level), 32'd0);

    // 6: asynchronous reset mid-stream
    reset_dut();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("s6_async_valid", 32'(out_valid), 32'd0);
    check_vec("s6_async_level", 32'(level), 32'd0);
    check_vec("s6_async_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    scen1();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
